alu_result_fifo: RTL and testbench

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_result_fifo.sv | 101 ++++++++++
 tb/tb_alu_result_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// Result queue for ALU outputs: tags each pushed result with status flags
// and returns entries strictly in order. Head fields read as zero when empty.
module alu_result_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_opcode,
    input  logic [3:0]                 in_a,
    input  logic [3:0]                 in_b,
    input  logic [7:0]                 in_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_result,
    output logic [2:0]                 out_opcode,
    output logic [3:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 15;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [2:0] OP_ADDC = 3'b100;
    localparam logic [2:0] OP_CMP  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_DIV  = 3'b111;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          push, pop;
    logic [3:0]    flags;
    logic [EW-1:0] head;

    // Flags are {OVF, DZ, C, Z}, captured alongside the result at push time.
    always_comb begin
        flags    = 4'b0000;
        flags[0] = (in_result == 8'h00);
        unique case (in_opcode)
            OP_ADDC: flags[1] = in_result[4];
            OP_CMP:  flags[1] = (in_a < in_b);
            default: flags[1] = 1'b0;
        endcase
        flags[2] = (in_opcode == OP_DIV) && (in_b == 4'h0);
        flags[3] = (in_opcode == OP_MUL) && (in_result[7:4] != 4'h0);
    end

    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wptr_q] <= {in_result, in_opcode, flags};
        end
    end

    assign head       = mem_q[rptr_q];
    assign out_result = out_valid ? head[14:7] : 8'h00;
    assign out_opcode = out_valid ? head[6:4]  : 3'b000;
    assign out_flags  = out_valid ? head[3:0]  : 4'b0000;
    assign count      = count_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo at DEPTH = 4.
module tb_alu_result_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [7:0] in_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [2:0] out_opcode;
    logic [3:0] out_flags;
    logic [2:0] count;

    int tests = 0;
    int fails = 0;

    alu_result_fifo #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_result  (in_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .out_flags  (out_flags),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] res);
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_result = res;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if ({out_result, out_opcode, out_flags} !== 15'h0) begin
            fails++; $display("FAIL reset_head got %h/%b/%b want zero", out_result, out_opcode, out_flags);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_opcode = 3'b100; in_a = 4'h9; in_b = 4'h8; in_result = 8'h11;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_no_bypass got %b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", out_valid); end
        tests++; if (out_result !== 8'h11) begin fails++; $display("FAIL single_result got %h want 11", out_result); end
        tests++; if (out_flags !== 4'b0010) begin fails++; $display("FAIL single_flags got %b want 0010", out_flags); end
        tests++; if (out_opcode !== 3'b100) begin fails++; $display("FAIL single_opcode got %b want 100", out_opcode); end
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL single_count got %0d want 1", count); end
        pop_one();
        tests++; if (count !== 3'd0 || out_valid !== 1'b0 || out_result !== 8'h00) begin
            fails++; $display("FAIL single_pop got count=%0d valid=%b res=%h want 0/0/00", count, out_valid, out_result);
        end
    endtask

    task automatic test_flags();
        logic [2:0] ops [8]  = '{3'b111, 3'b110, 3'b101, 3'b101, 3'b100, 3'b110, 3'b111, 3'b000};
        logic [3:0] as [8]   = '{4'h3, 4'hF, 4'h2, 4'h5, 4'h0, 4'h3, 4'h4, 4'h0};
        logic [3:0] bs [8]   = '{4'h0, 4'h2, 4'h5, 4'h2, 4'h0, 4'h3, 4'h2, 4'h0};
        logic [7:0] rs [8]   = '{8'h00, 8'h1E, 8'h07, 8'h03, 8'h0F, 8'h09, 8'h02, 8'h00};
        logic [3:0] fl [8]   = '{4'b0101, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        for (int i = 0; i < 8; i++) begin
            push_one(ops[i], as[i], bs[i], rs[i]);
            tests++; if (out_flags !== fl[i] || out_result !== rs[i]) begin
                fails++; $display("FAIL flags_vec%0d got flags=%b res=%h want flags=%b res=%h",
                                  i, out_flags, out_result, fl[i], rs[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_fill_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(3'b001, 4'h1, 4'h1, 8'h10 + 8'(i));
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count got %0d want 4", count); end
        push_one(3'b001, 4'h1, 4'h1, 8'h14);
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL overflow_count got %0d want 4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (out_valid !== 1'b1 || out_result !== 8'h10 + 8'(i)) begin
                fails++; $display("FAIL drain%0d got valid=%b res=%h want 1/%h", i, out_valid, out_result, 8'h10 + 8'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL drain_empty got count=%0d valid=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) push_one(3'b010, 4'h2, 4'h3, 8'h20 + 8'(i));
        in_valid = 1'b1; in_result = 8'h99; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL fullpop_count got %0d want 3", count); end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tests++; if (out_valid !== 1'b1 || out_result !== 8'h20 + 8'(i)) begin
                fails++; $display("FAIL fullpop_drain%0d got valid=%b res=%h want 1/%h", i, out_valid, out_result, 8'h20 + 8'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL fullpop_empty got count=%0d valid=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; out_ready = 1'b1; in_opcode = 3'b011; in_a = 4'h0; in_b = 4'h0;
        for (int i = 0; i < 10; i++) begin
            in_result = 8'h30 + 8'(i);
            if (i > 0) begin
                tests++; if (count !== 3'd1 || out_result !== 8'h30 + 8'(i - 1)) begin
                    fails++; $display("FAIL stream%0d got count=%0d res=%h want 1/%h", i, count, out_result, 8'h30 + 8'(i - 1));
                end
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tests++; if (count !== 3'd1 || out_result !== 8'h39) begin
            fails++; $display("FAIL stream_tail got count=%0d res=%h want 1/39", count, out_result);
        end
        pop_one();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) push_one(3'b001, 4'h0, 4'h0, 8'h40 + 8'(i));
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL midrst_pre got %0d want 3", count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (count !== 3'd0 || out_valid !== 1'b0 || out_result !== 8'h00) begin
            fails++; $display("FAIL midrst_clear got count=%0d valid=%b res=%h want 0/0/00", count, out_valid, out_result);
        end
        push_one(3'b001, 4'h0, 4'h0, 8'hA5);
        tests++; if (count !== 3'd1 || out_result !== 8'hA5) begin
            fails++; $display("FAIL midrst_head got count=%0d res=%h want 1/a5", count, out_result);
        end
        pop_one();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = 3'b000; in_a = 4'h0; in_b = 4'h0; in_result = 8'h00;
        #1;
        test_reset();
        test_single();
        test_flags();
        test_fill_overflow();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
